// File: rtl/control_sequencer.sv
// Microcode sequencer for an 8-bit breadboard-style CPU.
// A 3-bit T-state counter walks fetch (T0,T1) and execute (T2..T4) steps;
// all control lines are a combinational decode of step, opcode and flags.
module control_sequencer (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       co_n,
    output logic       ce,
    output logic       j_n,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       fi,
    output logic       hlt,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    step_e step_q, step_d;
    logic  halted_q, halted_d;

    // State register: reset abandons any instruction (including halt) at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Next step: each opcode ends at its last used T-state; HLT parks in T2.
    always_comb begin
        step_d   = T0;
        halted_d = halted_q;
        if (halted_q) begin
            step_d = T2;
        end else begin
            case (step_q)
                T0: step_d = T1;
                T1: step_d = T2;
                T2: begin
                    if (opcode == OP_HLT) begin
                        step_d   = T2;
                        halted_d = 1'b1;
                    end else if (opcode == OP_LDA || opcode == OP_ADD ||
                                 opcode == OP_SUB || opcode == OP_STA) begin
                        step_d = T3;
                    end else begin
                        step_d = T0;
                    end
                end
                T3: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) step_d = T4;
                    else                                      step_d = T0;
                end
                default: step_d = T0;
            endcase
        end
    end

    // Control decode: everything inactive unless the current step names it.
    always_comb begin
        co_n = 1'b1;
        j_n  = 1'b1;
        ce   = 1'b0;
        mi   = 1'b0;
        ri   = 1'b0;
        ro   = 1'b0;
        io   = 1'b0;
        ii   = 1'b0;
        ai   = 1'b0;
        ao   = 1'b0;
        eo   = 1'b0;
        su   = 1'b0;
        bi   = 1'b0;
        oi   = 1'b0;
        fi   = 1'b0;
        hlt  = 1'b0;
        if (halted_q) begin
            hlt = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    co_n = 1'b0;
                    mi   = 1'b1;
                end
                T1: begin
                    ro = 1'b1;
                    ii = 1'b1;
                    ce = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1;
                            mi = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        OP_JMP: begin
                            io  = 1'b1;
                            j_n = 1'b0;
                        end
                        OP_JC: begin
                            io  = cf;
                            j_n = ~cf;
                        end
                        OP_JZ: begin
                            io  = zf;
                            j_n = ~zf;
                        end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eo = 1'b1;
                        ai = 1'b1;
                        fi = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: fixed vector table, hand-written corner
// sequences, an opcode sweep and a randomized run against a microcode-table model.
module tb_control_sequencer;

    logic       clk;
    logic       clr_n;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;
    logic       co_n, ce, j_n, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, fi, hlt;
    logic [2:0] step;

    control_sequencer dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .opcode (opcode),
        .cf     (cf),
        .zf     (zf),
        .co_n   (co_n),
        .ce     (ce),
        .j_n    (j_n),
        .mi     (mi),
        .ri     (ri),
        .ro     (ro),
        .io     (io),
        .ii     (ii),
        .ai     (ai),
        .ao     (ao),
        .eo     (eo),
        .su     (su),
        .bi     (bi),
        .oi     (oi),
        .fi     (fi),
        .hlt    (hlt),
        .step   (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: one bit per line, set when the line is active.
    localparam logic [15:0] C_CO  = 16'h8000;
    localparam logic [15:0] C_CE  = 16'h4000;
    localparam logic [15:0] C_J   = 16'h2000;
    localparam logic [15:0] C_MI  = 16'h1000;
    localparam logic [15:0] C_RI  = 16'h0800;
    localparam logic [15:0] C_RO  = 16'h0400;
    localparam logic [15:0] C_IO  = 16'h0200;
    localparam logic [15:0] C_II  = 16'h0100;
    localparam logic [15:0] C_AI  = 16'h0080;
    localparam logic [15:0] C_AO  = 16'h0040;
    localparam logic [15:0] C_EO  = 16'h0020;
    localparam logic [15:0] C_SU  = 16'h0010;
    localparam logic [15:0] C_BI  = 16'h0008;
    localparam logic [15:0] C_OI  = 16'h0004;
    localparam logic [15:0] C_FI  = 16'h0002;
    localparam logic [15:0] C_HLT = 16'h0001;
    // co_n and j_n are active-low on the pins
    localparam logic [15:0] INV   = 16'hA000;

    logic [15:0] dut_word;
    assign dut_word = {co_n, ce, j_n, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, fi, hlt};

    int checks = 0;
    int errors = 0;

    // Reference model: microcode table per opcode and T-state, instruction length,
    // and which flag (if any) gates the T2 word.
    logic [15:0] ucode [16][5];
    int          ilen  [16];
    int          cond  [16];
    int          m_step;
    bit          m_halt;

    typedef struct {
        logic [3:0]  op;
        logic        cf;
        logic        zf;
        logic [2:0]  st;
        logic [15:0] mask;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] op, input logic c, input logic z,
                           input logic [2:0] st, input logic [15:0] mask);
        vec_t v;
        v.op = op; v.cf = c; v.zf = z; v.st = st; v.mask = mask;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] w;
        if (m_halt) return C_HLT;
        if (m_step == 0) return C_CO | C_MI;
        if (m_step == 1) return C_RO | C_II | C_CE;
        w = ucode[opcode][m_step];
        if (m_step == 2 && cond[opcode] == 1 && !cf) w = 16'h0;
        if (m_step == 2 && cond[opcode] == 2 && !zf) w = 16'h0;
        return w;
    endfunction

    task automatic model_advance();
        if (!clr_n) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_step = 2;
        end else if (m_step == 2 && opcode == 4'hF) begin
            m_halt = 1'b1;
        end else if (m_step + 1 >= ilen[opcode]) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    task automatic check(input string name, input logic [2:0] est, input logic [15:0] emask);
        checks++;
        if (step !== est || dut_word !== (emask ^ INV)) begin
            errors++;
            $display("FAIL %s: got step=%0d ctl=%h, want step=%0d ctl=%h",
                     name, step, dut_word, est, emask ^ INV);
        end else begin
            $display("ok   %s: step=%0d ctl=%h", name, step, dut_word);
        end
    endtask

    task automatic check_bus(input string name);
        checks++;
        if (co_n === 1'b0 && io === 1'b1) begin
            errors++;
            $display("FAIL %s bus: got co_n=%b io=%b, want not both driving", name, co_n, io);
        end
    endtask

    task automatic model_check(input string name);
        check(name, 3'(m_step), model_mask());
        check_bus(name);
    endtask

    // One clock: model follows the edge with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        tick();
        clr_n = 1'b1;
        #1;
    endtask

    initial begin
        int cycles;
        int exp_len;
        // ---------------- model tables ----------------
        for (int o = 0; o < 16; o++) begin
            ilen[o] = 3;
            cond[o] = 0;
            for (int s = 0; s < 5; s++) ucode[o][s] = 16'h0;
        end
        ucode[1][2]  = C_IO | C_MI;  ucode[1][3] = C_RO | C_AI;  ilen[1] = 4;
        ucode[2][2]  = C_IO | C_MI;  ucode[2][3] = C_RO | C_BI;
        ucode[2][4]  = C_EO | C_AI | C_FI;                       ilen[2] = 5;
        ucode[3][2]  = C_IO | C_MI;  ucode[3][3] = C_RO | C_BI;
        ucode[3][4]  = C_EO | C_AI | C_FI | C_SU;                ilen[3] = 5;
        ucode[4][2]  = C_IO | C_MI;  ucode[4][3] = C_AO | C_RI;  ilen[4] = 4;
        ucode[5][2]  = C_IO | C_AI;
        ucode[6][2]  = C_IO | C_J;
        ucode[7][2]  = C_IO | C_J;   cond[7] = 1;
        ucode[8][2]  = C_IO | C_J;   cond[8] = 2;
        ucode[14][2] = C_AO | C_OI;
        ucode[15][2] = C_HLT;

        // ---------------- vector table ----------------
        add_vec(4'h1, 0, 0, 0, C_CO | C_MI);
        add_vec(4'h1, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h1, 0, 0, 2, C_IO | C_MI);
        add_vec(4'h1, 0, 0, 3, C_RO | C_AI);
        add_vec(4'h3, 0, 0, 0, C_CO | C_MI);
        add_vec(4'h3, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h3, 0, 0, 2, C_IO | C_MI);
        add_vec(4'h3, 0, 0, 3, C_RO | C_BI);
        add_vec(4'h3, 0, 0, 4, C_EO | C_AI | C_FI | C_SU);
        add_vec(4'h2, 1, 1, 0, C_CO | C_MI);
        add_vec(4'h2, 1, 1, 1, C_RO | C_II | C_CE);
        add_vec(4'h2, 1, 1, 2, C_IO | C_MI);
        add_vec(4'h2, 1, 1, 3, C_RO | C_BI);
        add_vec(4'h2, 1, 1, 4, C_EO | C_AI | C_FI);
        add_vec(4'h7, 1, 0, 0, C_CO | C_MI);
        add_vec(4'h7, 1, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h7, 1, 0, 2, C_IO | C_J);
        add_vec(4'h7, 1, 1, 0, C_CO | C_MI);
        add_vec(4'h7, 1, 1, 1, C_RO | C_II | C_CE);
        add_vec(4'h7, 0, 1, 2, 16'h0);
        add_vec(4'h8, 0, 1, 0, C_CO | C_MI);
        add_vec(4'h8, 0, 1, 1, C_RO | C_II | C_CE);
        add_vec(4'h8, 0, 1, 2, C_IO | C_J);
        add_vec(4'h8, 1, 0, 0, C_CO | C_MI);
        add_vec(4'h8, 1, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h8, 1, 0, 2, 16'h0);
        add_vec(4'h6, 0, 0, 0, C_CO | C_MI);
        add_vec(4'h6, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h6, 0, 0, 2, C_IO | C_J);
        add_vec(4'h4, 0, 0, 0, C_CO | C_MI);
        add_vec(4'h4, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h4, 0, 0, 2, C_IO | C_MI);
        add_vec(4'h4, 0, 0, 3, C_AO | C_RI);
        add_vec(4'h5, 0, 0, 0, C_CO | C_MI);
        add_vec(4'h5, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'h5, 0, 0, 2, C_IO | C_AI);
        add_vec(4'hE, 0, 0, 0, C_CO | C_MI);
        add_vec(4'hE, 0, 0, 1, C_RO | C_II | C_CE);
        add_vec(4'hE, 0, 0, 2, C_AO | C_OI);
        add_vec(4'h0, 1, 1, 0, C_CO | C_MI);
        add_vec(4'h0, 1, 1, 1, C_RO | C_II | C_CE);
        add_vec(4'h0, 1, 1, 2, 16'h0);
        add_vec(4'hB, 1, 1, 0, C_CO | C_MI);
        add_vec(4'hB, 1, 1, 1, C_RO | C_II | C_CE);
        add_vec(4'hB, 1, 1, 2, 16'h0);
        add_vec(4'h0, 0, 0, 0, C_CO | C_MI);

        // ---------------- reset state ----------------
        clr_n  = 1'b0;
        opcode = 4'hF;
        cf     = 1'b0;
        zf     = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        #12;
        check("reset_hold", 3'd0, C_CO | C_MI);
        tick();
        check("reset_after_edge", 3'd0, C_CO | C_MI);
        clr_n = 1'b1;
        #1;

        // ---------------- vector table run ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            cf     = vecs[i].cf;
            zf     = vecs[i].zf;
            #1;
            check($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].st, vecs[i].mask);
            check_bus($sformatf("vec%0d", i));
            tick();
        end

        // ---------------- JC flag evaluated combinationally in T2 ----------------
        do_reset();
        opcode = 4'h7;
        cf = 1'b0;
        tick();
        tick();
        #1;
        check("jc_t2_cf0", 3'd2, 16'h0);
        cf = 1'b1;
        #1;
        check("jc_t2_cf1", 3'd2, C_IO | C_J);
        tick();
        check("jc_wrap", 3'd0, C_CO | C_MI);

        // ---------------- HLT then reset ----------------
        do_reset();
        opcode = 4'hF;
        tick();
        tick();
        check("hlt_t2", 3'd2, C_HLT);
        for (int k = 0; k < 10; k++) begin
            tick();
            opcode = 4'($urandom_range(0, 15));
            cf = 1'($urandom);
            zf = 1'($urandom);
            #1;
            check($sformatf("halted_%0d", k), 3'd2, C_HLT);
        end
        #1;
        clr_n = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        #1;
        check("hlt_clr_async", 3'd0, C_CO | C_MI);
        tick();
        check("hlt_clr_held", 3'd0, C_CO | C_MI);
        clr_n = 1'b1;
        opcode = 4'h0;
        #1;
        tick();
        check("hlt_restart", 3'd1, C_RO | C_II | C_CE);

        // ---------------- async reset mid-T3 of ADD ----------------
        do_reset();
        opcode = 4'h2;
        tick();
        tick();
        tick();
        check("add_t3", 3'd3, C_RO | C_BI);
        #2;
        clr_n = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        #1;
        check("add_abort_async", 3'd0, C_CO | C_MI);
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        check("add_abort_restart", 3'd1, C_RO | C_II | C_CE);

        // ---------------- sweep all non-halt opcodes and flag combos ----------------
        for (int o = 0; o < 15; o++) begin
            for (int f = 0; f < 4; f++) begin
                do_reset();
                opcode = 4'(o);
                cf = f[0];
                zf = f[1];
                exp_len = (o >= 1 && o <= 4) ? ((o == 2 || o == 3) ? 5 : 4) : 3;
                cycles = 0;
                do begin
                    #1;
                    model_check($sformatf("sweep_op%h_f%0d_t%0d", o, f, cycles));
                    tick();
                    cycles++;
                end while (step !== 3'd0 && cycles < 8);
                checks++;
                if (cycles != exp_len) begin
                    errors++;
                    $display("FAIL sweep_len_op%h: got %0d cycles, want %0d", o, cycles, exp_len);
                end
            end
        end

        // ---------------- randomized run ----------------
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_halt || m_step < 2) begin
                int r;
                r = $urandom_range(0, 15);
                if (r == 15 && $urandom_range(0, 7) != 0) r = 0;
                opcode = 4'(r);
            end
            cf = 1'($urandom);
            zf = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                clr_n = 1'b0;
                m_step = 0;
                m_halt = 1'b0;
                #1;
                model_check($sformatf("rand%0d_clr", n));
                #1;
                clr_n = 1'b1;
            end
            #1;
            model_check($sformatf("rand%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
